// File: rtl/decoder_deadlock_scheduler.sv
// Deadlock supervisor: times per-channel blocked episodes, reports tripped channels round-robin.
// Optional `DEADLOCK_TIMESTAMP_EN adds a free-running cycle counter and the rpt_time output.
`timescale 1ns/1ps

module decoder_deadlock_scheduler #(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic [NUM_MON-1:0] mon_idle,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_cycles,
`ifdef DEADLOCK_TIMESTAMP_EN
  output logic [31:0]        rpt_time,
`endif
  output logic               deadlock
);

  typedef enum logic {ARB, REPORT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_MON];
  logic [CNT_W-1:0]   cnt_d [NUM_MON];
  logic [NUM_MON-1:0] pending_q, pending_d;
  logic [NUM_MON-1:0] reported_q, reported_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   rpt_idx_q, rpt_idx_d;
  logic [CNT_W-1:0]   rpt_cycles_q, rpt_cycles_d;
  logic               deadlock_q, deadlock_d;
`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0]        time_q, time_d;
  logic [31:0]        rpt_time_q, rpt_time_d;
`endif

  logic [CNT_W-1:0]   thr;
  logic               handshake;
  logic               trip_any;
  logic               found;
  logic [IDX_W-1:0]   scan_idx;
  int                 scan_sum;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    reported_d   = reported_q;
    rr_ptr_d     = rr_ptr_q;
    rpt_idx_d    = rpt_idx_q;
    rpt_cycles_d = rpt_cycles_q;
    trip_any     = 1'b0;
    found        = 1'b0;
    scan_idx     = '0;
    scan_sum     = 0;
    thr          = (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;
    handshake    = (state_q == REPORT) && rpt_ready;
`ifdef DEADLOCK_TIMESTAMP_EN
    time_d       = time_q + 32'd1;
    rpt_time_d   = rpt_time_q;
`endif

    for (int i = 0; i < NUM_MON; i++) begin
      if (clear || !enable || !mon_block[i] || mon_idle[i]) cnt_d[i] = '0;
      else if (&cnt_q[i])                                     cnt_d[i] = cnt_q[i];
      else                                                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
      // A zero counter ends the episode one edge later, re-arming the channel.
      if (cnt_q[i] == '0) begin
        pending_d[i]  = 1'b0;
        reported_d[i] = 1'b0;
      end
      if (!clear && !reported_q[i] && (cnt_d[i] >= thr)) begin
        pending_d[i] = 1'b1;
        trip_any     = 1'b1;
      end
    end

    if (clear) begin
      pending_d  = '0;
      reported_d = '0;
      if (state_q == REPORT) pending_d[rpt_idx_q] = pending_q[rpt_idx_q];
    end
    deadlock_d = clear ? 1'b0 : (deadlock_q | trip_any);

    if (handshake) begin
      pending_d[rpt_idx_q] = 1'b0;
      if (!clear) reported_d[rpt_idx_q] = 1'b1;
      rr_ptr_d = (rpt_idx_q == IDX_W'(NUM_MON - 1)) ? '0 : rpt_idx_q + IDX_W'(1);
      state_d  = ARB;
    end

    if (state_q == ARB) begin
      for (int j = 0; j < NUM_MON; j++) begin
        scan_sum = int'(rr_ptr_q) + j;
        if (scan_sum >= NUM_MON) scan_sum = scan_sum - NUM_MON;
        scan_idx = IDX_W'(scan_sum);
        if (!found && pending_q[scan_idx]) begin
          found        = 1'b1;
          rpt_idx_d    = scan_idx;
          rpt_cycles_d = cnt_q[scan_idx];
          state_d      = REPORT;
`ifdef DEADLOCK_TIMESTAMP_EN
          rpt_time_d   = time_q;
`endif
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is reset too
  // because its value is architecturally visible through rpt_cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ARB;
      pending_q    <= '0;
      reported_q   <= '0;
      rr_ptr_q     <= '0;
      rpt_idx_q    <= '0;
      rpt_cycles_q <= '0;
      deadlock_q   <= 1'b0;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= '0;
`ifdef DEADLOCK_TIMESTAMP_EN
      time_q       <= '0;
      rpt_time_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      reported_q   <= reported_d;
      rr_ptr_q     <= rr_ptr_d;
      rpt_idx_q    <= rpt_idx_d;
      rpt_cycles_q <= rpt_cycles_d;
      deadlock_q   <= deadlock_d;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= cnt_d[i];
`ifdef DEADLOCK_TIMESTAMP_EN
      time_q       <= time_d;
      rpt_time_q   <= rpt_time_d;
`endif
    end
  end

  assign rpt_valid  = (state_q == REPORT);
  assign rpt_idx    = rpt_idx_q;
  assign rpt_cycles = rpt_cycles_q;
  assign deadlock   = deadlock_q;
`ifdef DEADLOCK_TIMESTAMP_EN
  assign rpt_time   = rpt_time_q;
`endif

endmodule
